// File: rtl/alu_seq_nbit.sv
// alu_seq_nbit: registered N-bit ALU with valid/ready handshakes on both sides.
// Sixteen opcodes, a stored carry for multi-word ADC/SBB chains, and Z/N/V
// status flags. Opcode 15 is an unsigned shift-add multiply that takes N cycles.
// All other opcodes have 1-cycle latency and can be accepted back to back.
//
// Ports:
//   clk, rst           clock, asynchronous active-high reset
//   in_valid/in_ready  request handshake; a, b, sel sampled on accept
//   out_valid/out_ready  result handshake; results hold while stalled
//   o, o_hi            result (MUL: low/high product halves; o_hi=0 otherwise)
//   co, z, neg, ov     carry/borrow, zero, negative, signed-overflow flags
module alu_seq_nbit #(
  parameter int N  = 4,
  parameter int CW = $clog2(N) + 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic [3:0]   sel,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] o,
  output logic [N-1:0] o_hi,
  output logic         co,
  output logic         z,
  output logic         neg,
  output logic         ov
);

  typedef enum logic {IDLE, BUSY} state_t;

  localparam logic [N:0] ONE = {{N{1'b0}}, 1'b1};

  state_t state, state_nx;

  logic             c_reg;
  logic [CW-1:0]    cnt;
  logic [2*N-1:0]   acc, mcand, acc_step;
  logic [N-1:0]     mplier;

  logic accept, is_mul, last_step, load_single, load_mul;

  assign in_ready    = (state == IDLE) && (!out_valid || out_ready);
  assign accept      = in_valid && in_ready;
  assign is_mul      = (sel == 4'd15);
  assign last_step   = (state == BUSY) && (cnt == CW'(N-1));
  assign load_single = accept && !is_mul;
  assign load_mul    = last_step;

  // One shift-add step: the product of the final step is what gets
  // registered, so the Nth step and the result load share one edge.
  assign acc_step = acc + (mplier[0] ? mcand : '0);

  // ---------------- single-cycle datapath ----------------
  function automatic logic ov_add(input logic sa, input logic sb, input logic sr);
    return (sa == sb) && (sr != sa);
  endfunction

  function automatic logic ov_sub(input logic sa, input logic sb, input logic sr);
    return (sa != sb) && (sr != sa);
  endfunction

  logic [N:0] cin, add_r, sub_r, inr_r, dcr_r, adc_r, sbb_r;
  logic [N-1:0] alu_o;
  logic         alu_co, alu_ov;

  // (N+1)-bit arithmetic; bit N is carry out, or borrow for subtracts.
  assign cin   = {{N{1'b0}}, c_reg};
  assign add_r = {1'b0, a} + {1'b0, b};
  assign sub_r = {1'b0, a} - {1'b0, b};
  assign inr_r = {1'b0, a} + ONE;
  assign dcr_r = {1'b0, b} - ONE;
  assign adc_r = add_r + cin;
  assign sbb_r = sub_r - cin;

  always_comb begin
    alu_o  = '0;
    alu_co = 1'b0;
    alu_ov = 1'b0;
    case (sel)
      4'd0: begin
        {alu_co, alu_o} = add_r;
        alu_ov = ov_add(a[N-1], b[N-1], add_r[N-1]);
      end
      4'd1: begin
        {alu_co, alu_o} = sub_r;
        alu_ov = ov_sub(a[N-1], b[N-1], sub_r[N-1]);
      end
      4'd2: begin
        {alu_co, alu_o} = inr_r;
        alu_ov = ov_add(a[N-1], 1'b0, inr_r[N-1]);
      end
      4'd3: begin
        {alu_co, alu_o} = dcr_r;
        alu_ov = ov_sub(b[N-1], 1'b0, dcr_r[N-1]);
      end
      4'd4: alu_o = a & b;
      4'd5: alu_o = a | b;
      4'd6: alu_o = a ^ b;
      4'd7: alu_o = ~b;
      4'd8: begin
        {alu_co, alu_o} = adc_r;
        alu_ov = ov_add(a[N-1], b[N-1], adc_r[N-1]);
      end
      4'd9: begin
        {alu_co, alu_o} = sbb_r;
        alu_ov = ov_sub(a[N-1], b[N-1], sbb_r[N-1]);
      end
      4'd10: begin
        alu_o  = {a[N-2:0], 1'b0};
        alu_co = a[N-1];
      end
      4'd11: begin
        alu_o  = {1'b0, a[N-1:1]};
        alu_co = a[0];
      end
      4'd12: begin
        alu_o  = {a[N-1], a[N-1:1]};
        alu_co = a[0];
      end
      4'd13: begin
        alu_o  = {a[N-2:0], a[N-1]};
        alu_co = a[N-1];
      end
      4'd14: begin
        // Compare: borrow/overflow of a-b, but o passes a through, so z/neg
        // describe a rather than the difference.
        alu_o  = a;
        alu_co = sub_r[N];
        alu_ov = ov_sub(a[N-1], b[N-1], sub_r[N-1]);
      end
      default: ;
    endcase
  end

  // ---------------- multiply FSM ----------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE: if (accept && is_mul) state_nx = BUSY;
      BUSY: if (last_step)        state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc    <= '0;
      mcand  <= '0;
      mplier <= '0;
      cnt    <= '0;
    end else if (accept && is_mul) begin
      acc    <= '0;
      mcand  <= {{N{1'b0}}, a};
      mplier <= b;
      cnt    <= '0;
    end else if (state == BUSY) begin
      acc    <= acc_step;
      mcand  <= mcand << 1;
      mplier <= mplier >> 1;
      cnt    <= cnt + CW'(1);
    end
  end

  // ---------------- result / flag registers ----------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      o         <= '0;
      o_hi      <= '0;
      co        <= 1'b0;
      z         <= 1'b0;
      neg       <= 1'b0;
      ov        <= 1'b0;
      c_reg     <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      if (load_single) begin
        o     <= alu_o;
        o_hi  <= '0;
        co    <= alu_co;
        z     <= (alu_o == '0);
        neg   <= alu_o[N-1];
        ov    <= alu_ov;
        c_reg <= alu_co;
      end else if (load_mul) begin
        o     <= acc_step[N-1:0];
        o_hi  <= acc_step[2*N-1:N];
        co    <= 1'b0;
        z     <= (acc_step == '0);
        neg   <= acc_step[2*N-1];
        ov    <= |acc_step[2*N-1:N];
        c_reg <= 1'b0;
      end

      if (load_single || load_mul) out_valid <= 1'b1;
      else if (out_ready)          out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_alu_seq_nbit.sv
// Bench for alu_seq_nbit (N=4): directed vectors, expected results queued at
// issue time and checked by an independent monitor on each output handshake.
module tb_alu_seq_nbit;
  localparam int N = 4;

  logic         clk = 1'b0;
  logic         rst, in_valid, in_ready, out_valid, out_ready;
  logic         co, z, neg, ov;
  logic [N-1:0] a, b, o, o_hi;
  logic [3:0]   sel;

  alu_seq_nbit #(.N(N)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .sel(sel), .out_valid(out_valid), .out_ready(out_ready),
    .o(o), .o_hi(o_hi), .co(co), .z(z), .neg(neg), .ov(ov)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    string        name;
    logic [N-1:0] o, hi;
    logic         co, z, n, v;
  } exp_t;

  exp_t sb[$];
  exp_t cur;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, req);
    end
  endtask

  function automatic exp_t mk(input string nm, input logic [N-1:0] eo, input logic [N-1:0] ehi,
                              input logic eco, input logic ez, input logic en, input logic ev);
    exp_t e;
    e.name = nm; e.o = eo; e.hi = ehi; e.co = eco; e.z = ez; e.n = en; e.v = ev;
    return e;
  endfunction

  // Monitor: a result is consumed on any edge where out_valid & out_ready.
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      if (sb.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_result actual=o:%0h o_hi:%0h required=no_result", o, o_hi);
      end else begin
        cur = sb.pop_front();
        chk({cur.name, "_o"},    32'(o),    32'(cur.o));
        chk({cur.name, "_o_hi"}, 32'(o_hi), 32'(cur.hi));
        chk({cur.name, "_co"},   32'(co),   32'(cur.co));
        chk({cur.name, "_z"},    32'(z),    32'(cur.z));
        chk({cur.name, "_neg"},  32'(neg),  32'(cur.n));
        chk({cur.name, "_ov"},   32'(ov),   32'(cur.v));
      end
    end
  end

  // Issue one request; entered and left at 1 time unit after a rising edge.
  task automatic op(input logic [3:0] s, input logic [N-1:0] aa, input logic [N-1:0] bb,
                    input bit push, input exp_t e);
    int i;
    i = 0;
    while (!in_ready && i < 20) begin
      @(posedge clk); #1;
      i++;
    end
    if (!in_ready) begin
      checks++;
      failures++;
      $display("FAIL %s_accept_timeout actual=in_ready:0 required=1", e.name);
    end
    sel = s; a = aa; b = bb; in_valid = 1'b1;
    if (push) sb.push_back(e);
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  initial begin
    int w;
    in_valid = 1'b0; a = '0; b = '0; sel = '0; out_ready = 1'b1; rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_o", 32'(o), 0);
    chk("rst_o_hi", 32'(o_hi), 0);
    chk("rst_co", 32'(co), 0);
    chk("rst_z", 32'(z), 0);
    chk("rst_neg", 32'(neg), 0);
    chk("rst_ov", 32'(ov), 0);
    chk("rst_out_valid", 32'(out_valid), 0);
    rst = 1'b0;
    #1;
    chk("rst_in_ready", 32'(in_ready), 1);

    // ADD with 1-cycle latency
    op(4'd0, 4'h9, 4'h8, 1, mk("add", 4'h1, 4'h0, 1, 0, 0, 1));
    chk("add_latency", 32'(out_valid), 1);

    op(4'd1,  4'h3, 4'h5, 1, mk("sub",  4'hE, 4'h0, 1, 0, 1, 0));
    op(4'd14, 4'h5, 4'h5, 1, mk("cmp",  4'h5, 4'h0, 0, 0, 0, 0));
    // carry chain, back to back
    op(4'd0,  4'hF, 4'h1, 1, mk("addf", 4'h0, 4'h0, 1, 1, 0, 0));
    op(4'd8,  4'h2, 4'h3, 1, mk("adc",  4'h6, 4'h0, 0, 0, 0, 0));
    op(4'd9,  4'h2, 4'h2, 1, mk("sbb",  4'h0, 4'h0, 0, 1, 0, 0));
    // remaining single-cycle opcodes
    op(4'd2,  4'h7, 4'h0, 1, mk("inr",  4'h8, 4'h0, 0, 0, 1, 1));
    op(4'd3,  4'h5, 4'h0, 1, mk("dcr",  4'hF, 4'h0, 1, 0, 1, 0));
    op(4'd4,  4'hC, 4'hA, 1, mk("and",  4'h8, 4'h0, 0, 0, 1, 0));
    op(4'd5,  4'h3, 4'h4, 1, mk("or",   4'h7, 4'h0, 0, 0, 0, 0));
    op(4'd6,  4'hF, 4'h5, 1, mk("xor",  4'hA, 4'h0, 0, 0, 1, 0));
    op(4'd7,  4'h0, 4'h5, 1, mk("not",  4'hA, 4'h0, 0, 0, 1, 0));
    op(4'd10, 4'h9, 4'h0, 1, mk("shl",  4'h2, 4'h0, 1, 0, 0, 0));
    op(4'd11, 4'h9, 4'h0, 1, mk("shr",  4'h4, 4'h0, 1, 0, 0, 0));
    op(4'd12, 4'h9, 4'h0, 1, mk("asr",  4'hC, 4'h0, 1, 0, 1, 0));
    @(posedge clk); #1;

    // MUL: busy for 4 cycles, a request during BUSY must be ignored
    op(4'd15, 4'hD, 4'hB, 1, mk("mul", 4'hF, 4'h8, 0, 0, 1, 1));
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("mul_busy_in_ready_%0d", i), 32'(in_ready), 0);
      chk($sformatf("mul_busy_out_valid_%0d", i), 32'(out_valid), 0);
      sel = 4'd0; a = 4'h1; b = 4'h1;
      in_valid = (i < 3);
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    chk("mul_out_valid_at_4", 32'(out_valid), 1);
    @(posedge clk); #1;

    // backpressure on a ROL result
    out_ready = 1'b0;
    op(4'd13, 4'h9, 4'h0, 1, mk("rol", 4'h3, 4'h0, 1, 0, 0, 0));
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("stall_out_valid_%0d", i), 32'(out_valid), 1);
      chk($sformatf("stall_o_%0d", i), 32'(o), 32'h3);
      chk($sformatf("stall_co_%0d", i), 32'(co), 1);
      chk($sformatf("stall_z_%0d", i), 32'(z), 0);
      chk($sformatf("stall_in_ready_%0d", i), 32'(in_ready), 0);
      @(posedge clk); #1;
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    chk("release_out_valid", 32'(out_valid), 0);
    chk("release_in_ready", 32'(in_ready), 1);

    // reset in the middle of a multiply: no result may appear
    op(4'd15, 4'h7, 4'h3, 0, mk("mul_abort", 4'h5, 4'h1, 0, 0, 0, 0));
    @(posedge clk); #1;
    rst = 1'b1;
    #1;
    chk("abort_o", 32'(o), 0);
    chk("abort_o_hi", 32'(o_hi), 0);
    chk("abort_co", 32'(co), 0);
    chk("abort_out_valid", 32'(out_valid), 0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    #1;
    chk("abort_in_ready", 32'(in_ready), 1);
    repeat (4) @(posedge clk);
    #1;
    chk("abort_no_result", 32'(out_valid), 0);
    op(4'd0, 4'h1, 4'h1, 1, mk("add_after_rst", 4'h2, 4'h0, 0, 0, 0, 0));

    w = 0;
    while (sb.size() != 0 && w < 20) begin
      @(posedge clk); #1;
      w++;
    end
    chk("scoreboard_drained", 32'(sb.size()), 0);
    repeat (2) @(posedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
